// File: rtl/regfile_pkg.sv
// Shared types and helpers for the speculative register file.
package regfile_pkg;

  // Widest address and data any instance may use; write requests are carried at these widths.
  localparam int unsigned MaxAddrBits = 16;
  localparam int unsigned MaxDataBits = 64;

  typedef struct packed {
    logic                   en;
    logic [MaxAddrBits-1:0] addr;
    logic [MaxDataBits-1:0] data;
  } writeReq_t;

  function automatic int unsigned addrBits(input int unsigned regCount);
    return $clog2(regCount);
  endfunction

  // Pending-counter saturation value for a counter of the given width.
  function automatic int unsigned pendingSat(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/speculative_register_file_cell.sv
// One register: committed value, optional shadow with spec bit, and pending-write counter.
// Shadow storage is built only when SPECULATIVE_REGFILE_SHADOW_EN is defined.
module speculative_register_file_cell
  import regfile_pkg::*;
#(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned WRITEPORTS   = 2,
  parameter int unsigned PENDINGBITS  = 2
) (
  input  logic                    clk,
  input  logic                    async_rst_n,
  input  logic                    clk_en,
  input  logic                    Speculating,
  input  logic                    EndSpeculationPulse,
  input  logic                    MispredictedSpeculationPulse,
  input  logic [WRITEPORTS-1:0]   writeHit,
  input  logic [DATABITWIDTH-1:0] writeData,
  input  logic                    reserveHit,
  output logic [DATABITWIDTH-1:0] readValue,
  output logic                    specBit,
  output logic                    pending,
  output logic                    reserveStall
);

  localparam logic [PENDINGBITS-1:0] CountMax = PENDINGBITS'(pendingSat(PENDINGBITS));

  logic [DATABITWIDTH-1:0] committedQ, committedD;
  logic [PENDINGBITS-1:0]  countQ, countD;
  logic                    anyWrite;
  int                      nWrites;
  int                      countNext;

  always_comb begin
    anyWrite = |writeHit;
    nWrites  = 0;
    for (int p = 0; p < int'(WRITEPORTS); p++) begin
      if (writeHit[p]) nWrites++;
    end
    reserveStall = reserveHit && (countQ == CountMax) && !anyWrite;
    countNext = 0;
    countNext[PENDINGBITS-1:0] = countQ;
    if (reserveHit && !reserveStall) countNext++;
    countNext = countNext - nWrites;
    // Writes with nothing outstanding are clamped rather than wrapping.
    if (countNext < 0) countNext = 0;
    countD = countNext[PENDINGBITS-1:0];
  end

  assign pending = (countQ != '0);

`ifdef SPECULATIVE_REGFILE_SHADOW_EN
  logic [DATABITWIDTH-1:0] shadowQ, shadowD;
  logic                    specQ, specD;

  always_comb begin
    committedD = committedQ;
    shadowD    = shadowQ;
    specD      = specQ;
    if (MispredictedSpeculationPulse) begin
      specD = 1'b0;
      if (anyWrite) committedD = writeData;
    end else if (EndSpeculationPulse) begin
      specD = 1'b0;
      if (anyWrite)   committedD = writeData;
      else if (specQ) committedD = shadowQ;
    end else if (anyWrite) begin
      if (Speculating) begin
        shadowD = writeData;
        specD   = 1'b1;
      end else begin
        committedD = writeData;
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      committedQ <= '0;
      shadowQ    <= '0;
      specQ      <= 1'b0;
      countQ     <= '0;
    end else if (clk_en) begin
      committedQ <= committedD;
      shadowQ    <= shadowD;
      specQ      <= specD;
      countQ     <= countD;
    end
  end

  assign readValue = specQ ? shadowQ : committedQ;
  assign specBit   = specQ;
`else
  logic unusedSpecInputs;
  assign unusedSpecInputs = Speculating ^ EndSpeculationPulse ^ MispredictedSpeculationPulse;

  assign committedD = anyWrite ? writeData : committedQ;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      committedQ <= '0;
      countQ     <= '0;
    end else if (clk_en) begin
      committedQ <= committedD;
      countQ     <= countD;
    end
  end

  assign readValue = committedQ;
  assign specBit   = 1'b0;
`endif

endmodule

// File: rtl/speculative_register_file.sv
// Multi-port register file with pending-write scoreboard and single-level speculation shadow.
// Shadow/speculation support is enabled by defining SPECULATIVE_REGFILE_SHADOW_EN.
module speculative_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned REGCOUNT     = 16,
  parameter int unsigned READPORTS    = 2,
  parameter int unsigned WRITEPORTS   = 2,
  parameter int unsigned PENDINGBITS  = 2,
  localparam int unsigned ADDRBITS    = addrBits(REGCOUNT)
) (
  input  logic                                     clk,
  input  logic                                     async_rst_n,
  input  logic                                     clk_en,
  input  logic                                     Speculating,
  input  logic                                     EndSpeculationPulse,
  input  logic                                     MispredictedSpeculationPulse,
  input  logic [READPORTS-1:0][ADDRBITS-1:0]       ReadAddr,
  output logic [READPORTS-1:0][DATABITWIDTH-1:0]   ReadData,
  output logic [READPORTS-1:0]                     ReadReady,
  input  logic                                     ReserveEn,
  input  logic [ADDRBITS-1:0]                      ReserveAddr,
  output logic                                     ReserveStall,
  input  logic [WRITEPORTS-1:0]                    WriteEn,
  input  logic [WRITEPORTS-1:0][ADDRBITS-1:0]      WriteAddr,
  input  logic [WRITEPORTS-1:0][DATABITWIDTH-1:0]  WriteData,
  output logic [REGCOUNT-1:0]                      SpeculativeVector,
  output logic [REGCOUNT-1:0]                      PendingVector
);

  writeReq_t                                writeReq [WRITEPORTS];
  logic                                     unusedReq;
  logic [REGCOUNT-1:1][WRITEPORTS-1:0]      writeHit;
  logic [REGCOUNT-1:1][DATABITWIDTH-1:0]    selData;
  logic [REGCOUNT-1:1]                      reserveHit;
  logic [REGCOUNT-1:0]                      stallVec;
  logic [DATABITWIDTH-1:0]                  regValue [REGCOUNT];

  always_comb begin
    unusedReq = 1'b0;
    for (int p = 0; p < int'(WRITEPORTS); p++) begin
      writeReq[p]                     = '0;
      writeReq[p].en                  = WriteEn[p];
      writeReq[p].addr[ADDRBITS-1:0]  = WriteAddr[p];
      writeReq[p].data[DATABITWIDTH-1:0] = WriteData[p];
      unusedReq = unusedReq ^ (^writeReq[p]);
    end
  end

  // Decode per register; the loop order makes the highest-indexed port win the data.
  always_comb begin
    for (int r = 1; r < int'(REGCOUNT); r++) begin
      selData[r]    = '0;
      reserveHit[r] = ReserveEn && (ReserveAddr == ADDRBITS'(r));
      for (int p = 0; p < int'(WRITEPORTS); p++) begin
        writeHit[r][p] = writeReq[p].en && (writeReq[p].addr == MaxAddrBits'(r));
        if (writeHit[r][p]) selData[r] = writeReq[p].data[DATABITWIDTH-1:0];
      end
    end
  end

  for (genvar r = 0; r < int'(REGCOUNT); r++) begin : gReg
    if (r == 0) begin : gZero
      assign regValue[r]          = '0;
      assign SpeculativeVector[r] = 1'b0;
      assign PendingVector[r]     = 1'b0;
      assign stallVec[r]          = 1'b0;
    end else begin : gCell
      speculative_register_file_cell #(
        .DATABITWIDTH (DATABITWIDTH),
        .WRITEPORTS   (WRITEPORTS),
        .PENDINGBITS  (PENDINGBITS)
      ) uCell (
        .clk                          (clk),
        .async_rst_n                  (async_rst_n),
        .clk_en                       (clk_en),
        .Speculating                  (Speculating),
        .EndSpeculationPulse          (EndSpeculationPulse),
        .MispredictedSpeculationPulse (MispredictedSpeculationPulse),
        .writeHit                     (writeHit[r]),
        .writeData                    (selData[r]),
        .reserveHit                   (reserveHit[r]),
        .readValue                    (regValue[r]),
        .specBit                      (SpeculativeVector[r]),
        .pending                      (PendingVector[r]),
        .reserveStall                 (stallVec[r])
      );
    end
  end

  assign ReserveStall = |stallVec;

  always_comb begin
    for (int i = 0; i < int'(READPORTS); i++) begin
      ReadData[i]  = regValue[ReadAddr[i]];
      ReadReady[i] = ~PendingVector[ReadAddr[i]];
    end
  end

endmodule

// File: tb/tb_speculative_register_file.sv
// Directed self-checking bench for speculative_register_file (default parameters).
module tb_speculative_register_file;

`ifdef SPECULATIVE_REGFILE_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             async_rst_n;
  logic             clk_en;
  logic             Speculating;
  logic             EndSpeculationPulse;
  logic             MispredictedSpeculationPulse;
  logic [1:0][3:0]  ReadAddr;
  logic [1:0][15:0] ReadData;
  logic [1:0]       ReadReady;
  logic             ReserveEn;
  logic [3:0]       ReserveAddr;
  logic             ReserveStall;
  logic [1:0]       WriteEn;
  logic [1:0][3:0]  WriteAddr;
  logic [1:0][15:0] WriteData;
  logic [15:0]      SpeculativeVector;
  logic [15:0]      PendingVector;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  speculative_register_file dut (
    .clk                          (clk),
    .async_rst_n                  (async_rst_n),
    .clk_en                       (clk_en),
    .Speculating                  (Speculating),
    .EndSpeculationPulse          (EndSpeculationPulse),
    .MispredictedSpeculationPulse (MispredictedSpeculationPulse),
    .ReadAddr                     (ReadAddr),
    .ReadData                     (ReadData),
    .ReadReady                    (ReadReady),
    .ReserveEn                    (ReserveEn),
    .ReserveAddr                  (ReserveAddr),
    .ReserveStall                 (ReserveStall),
    .WriteEn                      (WriteEn),
    .WriteAddr                    (WriteAddr),
    .WriteData                    (WriteData),
    .SpeculativeVector            (SpeculativeVector),
    .PendingVector                (PendingVector)
  );

  task automatic idle();
    Speculating = 1'b0;
    EndSpeculationPulse = 1'b0;
    MispredictedSpeculationPulse = 1'b0;
    ReserveEn = 1'b0;
    ReserveAddr = '0;
    WriteEn = '0;
    WriteAddr = '0;
    WriteData = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input logic [3:0] a, input logic [15:0] d);
    WriteEn[port] = 1'b1;
    WriteAddr[port] = a;
    WriteData[port] = d;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    ReadAddr[0] = a0;
    ReadAddr[1] = a1;
    #1;
  endtask

  task automatic test_reset();
    #12;
    rd(4'd3, 4'd5);
    compared++;
    if (ReadData[0] !== 16'h0) begin
      mismatched++; $display("FAIL reset_rd0: got %h want %h", ReadData[0], 16'h0);
    end
    compared++;
    if (ReadData[1] !== 16'h0) begin
      mismatched++; $display("FAIL reset_rd1: got %h want %h", ReadData[1], 16'h0);
    end
    compared++;
    if (ReadReady !== 2'b11) begin
      mismatched++; $display("FAIL reset_ready: got %b want %b", ReadReady, 2'b11);
    end
    compared++;
    if (ReserveStall !== 1'b0) begin
      mismatched++; $display("FAIL reset_stall: got %b want 0", ReserveStall);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL reset_specvec: got %h want 0000", SpeculativeVector);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL reset_pendvec: got %h want 0000", PendingVector);
    end
    @(negedge clk);
    async_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    wr(0, 4'd3, 16'h1234);
    tick(); idle();
    rd(4'd3, 4'd0);
    compared++;
    if (ReadData[0] !== 16'h1234) begin
      mismatched++; $display("FAIL write_r3: got %h want %h", ReadData[0], 16'h1234);
    end
    compared++;
    if (ReadData[1] !== 16'h0) begin
      mismatched++; $display("FAIL write_r0: got %h want %h", ReadData[1], 16'h0);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL write_specvec: got %h want 0000", SpeculativeVector);
    end
  endtask

  task automatic test_speculation();
    logic [15:0] exp;
    wr(0, 4'd5, 16'h0001);
    tick(); idle();
    Speculating = 1'b1;
    wr(0, 4'd5, 16'hBEEF);
    tick(); idle();
    rd(4'd5, 4'd5);
    compared++;
    if (ReadData[0] !== 16'hBEEF) begin
      mismatched++; $display("FAIL spec_read: got %h want %h", ReadData[0], 16'hBEEF);
    end
    exp = Shadow ? 16'h0020 : 16'h0000;
    compared++;
    if (SpeculativeVector !== exp) begin
      mismatched++; $display("FAIL spec_vec: got %h want %h", SpeculativeVector, exp);
    end
    MispredictedSpeculationPulse = 1'b1;
    tick(); idle();
    rd(4'd5, 4'd5);
    exp = Shadow ? 16'h0001 : 16'hBEEF;
    compared++;
    if (ReadData[0] !== exp) begin
      mismatched++; $display("FAIL mispredict_read: got %h want %h", ReadData[0], exp);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL mispredict_vec: got %h want 0000", SpeculativeVector);
    end
  endtask

  task automatic test_commit();
    logic [15:0] exp;
    Speculating = 1'b1;
    wr(0, 4'd5, 16'hBEEF);
    tick(); idle();
    EndSpeculationPulse = 1'b1;
    Speculating = 1'b1;
    wr(1, 4'd5, 16'h00AA);
    tick(); idle();
    rd(4'd5, 4'd0);
    compared++;
    if (ReadData[0] !== 16'h00AA) begin
      mismatched++; $display("FAIL end_override: got %h want %h", ReadData[0], 16'h00AA);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL end_vec: got %h want 0000", SpeculativeVector);
    end
    // Plain commit survives a later mispredict.
    Speculating = 1'b1;
    wr(0, 4'd6, 16'h5555);
    tick(); idle();
    EndSpeculationPulse = 1'b1;
    tick(); idle();
    MispredictedSpeculationPulse = 1'b1;
    tick(); idle();
    rd(4'd6, 4'd0);
    compared++;
    if (ReadData[0] !== 16'h5555) begin
      mismatched++; $display("FAIL end_commit: got %h want %h", ReadData[0], 16'h5555);
    end
    // Both pulses together: mispredict wins.
    Speculating = 1'b1;
    wr(0, 4'd6, 16'h7777);
    tick(); idle();
    EndSpeculationPulse = 1'b1;
    MispredictedSpeculationPulse = 1'b1;
    tick(); idle();
    rd(4'd6, 4'd0);
    exp = Shadow ? 16'h5555 : 16'h7777;
    compared++;
    if (ReadData[0] !== exp) begin
      mismatched++; $display("FAIL both_pulses: got %h want %h", ReadData[0], exp);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL both_pulses_vec: got %h want 0000", SpeculativeVector);
    end
  endtask

  task automatic test_scoreboard();
    ReserveEn = 1'b1;
    ReserveAddr = 4'd7;
    repeat (3) tick();
    idle();
    rd(4'd7, 4'd0);
    compared++;
    if (PendingVector !== 16'h0080) begin
      mismatched++; $display("FAIL sb_pendvec: got %h want %h", PendingVector, 16'h0080);
    end
    compared++;
    if (ReadReady !== 2'b10) begin
      mismatched++; $display("FAIL sb_ready: got %b want %b", ReadReady, 2'b10);
    end
    ReserveEn = 1'b1;
    ReserveAddr = 4'd7;
    #1;
    compared++;
    if (ReserveStall !== 1'b1) begin
      mismatched++; $display("FAIL sb_stall: got %b want 1", ReserveStall);
    end
    tick(); idle();
    // Saturated reserve with a same-cycle write is accepted and nets to zero.
    ReserveEn = 1'b1;
    ReserveAddr = 4'd7;
    wr(0, 4'd7, 16'h0077);
    #1;
    compared++;
    if (ReserveStall !== 1'b0) begin
      mismatched++; $display("FAIL sb_stall_with_write: got %b want 0", ReserveStall);
    end
    tick(); idle();
    wr(0, 4'd7, 16'h0701);
    tick();
    wr(0, 4'd7, 16'h0702);
    tick(); idle();
    rd(4'd7, 4'd0);
    compared++;
    if (ReadReady[0] !== 1'b0) begin
      mismatched++; $display("FAIL sb_ready_after2: got %b want 0", ReadReady[0]);
    end
    wr(0, 4'd7, 16'h0703);
    tick(); idle();
    rd(4'd7, 4'd0);
    compared++;
    if (ReadReady[0] !== 1'b1) begin
      mismatched++; $display("FAIL sb_ready_after3: got %b want 1", ReadReady[0]);
    end
    compared++;
    if (ReadData[0] !== 16'h0703) begin
      mismatched++; $display("FAIL sb_data: got %h want %h", ReadData[0], 16'h0703);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL sb_pend_clear: got %h want 0000", PendingVector);
    end
  endtask

  task automatic test_back_to_back();
    ReserveEn = 1'b1;
    ReserveAddr = 4'd2;
    repeat (2) tick();
    idle();
    rd(4'd2, 4'd0);
    compared++;
    if (PendingVector !== 16'h0004) begin
      mismatched++; $display("FAIL b2b_pend: got %h want %h", PendingVector, 16'h0004);
    end
    wr(0, 4'd2, 16'h1111);
    wr(1, 4'd2, 16'h2222);
    tick(); idle();
    rd(4'd2, 4'd0);
    compared++;
    if (ReadData[0] !== 16'h2222) begin
      mismatched++; $display("FAIL b2b_priority: got %h want %h", ReadData[0], 16'h2222);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL b2b_count: got %h want 0000", PendingVector);
    end
    wr(0, 4'd2, 16'h3333);
    tick(); idle();
    rd(4'd2, 4'd2);
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL underflow_clamp: got %h want 0000", PendingVector);
    end
    compared++;
    if (ReadData[1] !== 16'h3333) begin
      mismatched++; $display("FAIL underflow_data: got %h want %h", ReadData[1], 16'h3333);
    end
    ReserveEn = 1'b1;
    ReserveAddr = 4'd0;
    wr(0, 4'd0, 16'h5555);
    #1;
    compared++;
    if (ReserveStall !== 1'b0) begin
      mismatched++; $display("FAIL r0_stall: got %b want 0", ReserveStall);
    end
    tick(); idle();
    rd(4'd0, 4'd0);
    compared++;
    if (ReadData[0] !== 16'h0) begin
      mismatched++; $display("FAIL r0_data: got %h want 0000", ReadData[0]);
    end
    compared++;
    if (ReadReady !== 2'b11) begin
      mismatched++; $display("FAIL r0_ready: got %b want 11", ReadReady);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL r0_pend: got %h want 0000", PendingVector);
    end
  endtask

  task automatic test_clk_en();
    logic [15:0] exp;
    Speculating = 1'b1;
    wr(0, 4'd4, 16'h4444);
    tick(); idle();
    clk_en = 1'b0;
    wr(0, 4'd3, 16'hFFFF);
    EndSpeculationPulse = 1'b1;
    ReserveEn = 1'b1;
    ReserveAddr = 4'd9;
    tick(); tick(); idle();
    clk_en = 1'b1;
    rd(4'd3, 4'd4);
    compared++;
    if (ReadData[0] !== 16'h1234) begin
      mismatched++; $display("FAIL clken_data: got %h want %h", ReadData[0], 16'h1234);
    end
    compared++;
    if (ReadData[1] !== 16'h4444) begin
      mismatched++; $display("FAIL clken_spec_data: got %h want %h", ReadData[1], 16'h4444);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL clken_pend: got %h want 0000", PendingVector);
    end
    exp = Shadow ? 16'h0010 : 16'h0000;
    compared++;
    if (SpeculativeVector !== exp) begin
      mismatched++; $display("FAIL clken_specvec: got %h want %h", SpeculativeVector, exp);
    end
  endtask

  task automatic test_reset_mid();
    ReserveEn = 1'b1;
    ReserveAddr = 4'd8;
    tick(); idle();
    rd(4'd4, 4'd8);
    compared++;
    if (PendingVector !== 16'h0100) begin
      mismatched++; $display("FAIL pre_reset_pend: got %h want %h", PendingVector, 16'h0100);
    end
    #2;
    async_rst_n = 1'b0;
    #1;
    compared++;
    if (ReadData[0] !== 16'h0) begin
      mismatched++; $display("FAIL midreset_r4: got %h want 0000", ReadData[0]);
    end
    compared++;
    if (SpeculativeVector !== 16'h0) begin
      mismatched++; $display("FAIL midreset_specvec: got %h want 0000", SpeculativeVector);
    end
    compared++;
    if (PendingVector !== 16'h0) begin
      mismatched++; $display("FAIL midreset_pend: got %h want 0000", PendingVector);
    end
    compared++;
    if (ReadReady !== 2'b11) begin
      mismatched++; $display("FAIL midreset_ready: got %b want 11", ReadReady);
    end
    rd(4'd3, 4'd5);
    compared++;
    if (ReadData[0] !== 16'h0) begin
      mismatched++; $display("FAIL midreset_r3: got %h want 0000", ReadData[0]);
    end
    @(negedge clk);
    async_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    ReadAddr = '0;
    clk_en = 1'b1;
    async_rst_n = 1'b0;
    test_reset();
    test_write();
    test_speculation();
    test_commit();
    test_scoreboard();
    test_back_to_back();
    test_clk_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
